div_unit: RTL and testbench
===========================

# div_unit

Iterative 32-bit signed/unsigned divider for the execute stage. It computes quotient (LO) and remainder (HI) for div/divu over multiple cycles. While it works it drives the execute-stage ALU stall consumed by the hazard unit, and it obeys that unit's exception flush and cache-stall hold. It is the stall source and flush responder on the ALU side of the hazard interface.

## Interface
Parameters:
- WIDTH, 32, operand and result width; counter width is clog2(WIDTH).

Ports (clock `clk`, reset `rst`, one clock; reset is synchronous and active-high):
- clk  in  1  pipeline clock
- rst  in  1  synchronous active-high reset
- div_startE  in  1  E-stage instruction is div/divu; held high while the instruction sits in E
- signed_divE  in  1  1 = div (signed), 0 = divu
- a  in  WIDTH  dividend (rs value, already forwarded)
- b  in  WIDTH  divisor (rt value)
- flush  in  1  exception flush (flush_exceptionM); aborts any operation
- cache_stall  in  1  combined I/D cache stall; E stage is frozen while high
- div_stall  out  1  to hazard alu_stallE
- result_valid  out  1  hi/lo hold the final result this cycle
- hi_out  out  WIDTH  remainder
- lo_out  out  WIDTH  quotient

## Operation
- States: IDLE, BUSY, DONE. Reset value is IDLE, counter 0, hi_out/lo_out 0, result_valid 0.
- div_stall = ~flush & ((IDLE & div_startE) | BUSY). It is combinational, so it asserts in the same cycle the div reaches E.
- IDLE:
  - If div_startE & ~flush: latch |a| and |b| (magnitudes when signed_divE, raw values otherwise), latch the quotient sign (a[MSB]^b[MSB]) and remainder sign (a[MSB]), each gated by signed_divE. Clear the partial remainder. Counter = 0. Go to BUSY.
- BUSY: one restoring step per cycle.
  - rem' = {rem, q[MSB]} - divisor_mag. If non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
  - Counter increments each cycle. On the cycle the counter = WIDTH-1, apply signs (two's-complement negate of quotient/remainder per the latched signs), load hi_out/lo_out, and go to DONE.
- DONE: result_valid = 1, div_stall = 0.
  - Stay while cache_stall = 1; the instruction is still in E, and div_startE being high must not restart the operation.
  - Go to IDLE on the first cycle cache_stall = 0.
- flush: from any state, go to IDLE at the next edge. result_valid is forced 0 that cycle. hi_out/lo_out keep their last completed values.
- hi_out/lo_out change only when a result completes or on reset.
- Divide by zero is not trapped and gives deterministic results:
  - unsigned: lo = 0xFFFFFFFF, hi = a.
  - signed: lo = (a<0 ? 0x00000001 : 0xFFFFFFFF), hi = a.
- Signed overflow (0x80000000 / -1) gives lo = 0x80000000, hi = 0 (natural result of the magnitude path).

## Timing
- Accept cycle is cycle 0 (IDLE with div_startE). BUSY occupies cycles 1..WIDTH.
- div_stall is high for exactly WIDTH+1 = 33 cycles (cycles 0..32) when there is no flush.
- result_valid is first high in cycle 33. The hazard unit releases E that cycle if cache_stall = 0.
- Back-to-back divides: the second div enters E the cycle after DONE exits. IDLE accepts it with no bubble beyond its own 33 stall cycles.
- flush in the same cycle as div_startE: no accept, div_stall = 0, state stays IDLE.
- flush mid-BUSY: div_stall drops in that cycle; the next cycle is IDLE.
- rst has priority over flush and over all transitions. rst mid-BUSY gives IDLE with all outputs 0 on the next cycle.

## Test plan
- Unsigned 100 / 7: div_stall high for exactly 33 cycles, then result_valid = 1, lo = 14, hi = 2.
- Signed -7 / 2 (a = 0xFFFFFFF9, b = 2): lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
- Signed 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
- Divide by zero:
  - unsigned 5 / 0: lo = 0xFFFFFFFF, hi = 5.
  - signed -5 / 0: lo = 1, hi = 0xFFFFFFFB.
- Hold and restart:
  - With cache_stall held high for 3 cycles after completion: result_valid stays high 3 cycles, no restart while div_startE stays high, IDLE after cache_stall falls.
  - A second div (20 / 3) then takes 33 stall cycles and gives lo = 6, hi = 2.
- Abort:
  - flush at BUSY cycle 10: div_stall = 0 that cycle, IDLE next, hi/lo unchanged.
  - rst at BUSY cycle 5: all outputs 0 next cycle; a following 9 / 3 gives lo = 3, hi = 0.

Source files
------------

// File: rtl/div_unit.sv
// div_unit: iterative restoring divider for div/divu in the execute stage.
// Produces quotient (lo_out) and remainder (hi_out) after WIDTH step cycles,
// stalling E while busy and honouring exception flush and cache-stall hold.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   div_startE    E-stage instruction is div/divu (held while in E)
//   signed_divE   1 = signed div, 0 = divu
//   a, b          dividend / divisor
//   flush         exception flush, aborts any operation
//   cache_stall   E frozen; holds the DONE state
//   div_stall     combinational ALU stall to the hazard unit
//   result_valid  combinational, hi/lo hold the final result this cycle
//   hi_out        remainder (registered)
//   lo_out        quotient (registered)
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_startE,
  input  logic             signed_divE,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             cache_stall,
  output logic             div_stall,
  output logic             result_valid,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;   // dividend shifts out, quotient shifts in
  logic [WIDTH-1:0] dvs_q, dvs_d;   // divisor magnitude
  logic [WIDTH-1:0] rem_q, rem_d;   // partial remainder
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  // One restoring step on the current partial remainder.
  logic [WIDTH:0]   shifted;
  logic             fits;
  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quo;

  always_comb begin
    shifted  = {rem_q, quo_q[WIDTH-1]};
    fits     = (shifted >= {1'b0, dvs_q});
    step_rem = fits ? WIDTH'(shifted - {1'b0, dvs_q}) : shifted[WIDTH-1:0];
    step_quo = {quo_q[WIDTH-2:0], fits};
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    unique case (state_q)
      S_IDLE: begin
        if (div_startE && !flush) begin
          quo_d   = (signed_divE && a[WIDTH-1]) ? -a : a;
          dvs_d   = (signed_divE && b[WIDTH-1]) ? -b : b;
          qneg_d  = signed_divE & (a[WIDTH-1] ^ b[WIDTH-1]);
          rneg_d  = signed_divE & a[WIDTH-1];
          rem_d   = '0;
          cnt_d   = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            lo_d    = qneg_q ? -step_quo : step_quo;
            hi_d    = rneg_q ? -step_rem : step_rem;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        // Hold while E is frozen; a still-high div_startE must not restart.
        if (flush || !cache_stall) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Stall asserts in the accept cycle itself so E freezes immediately.
  assign div_stall    = ~flush & (((state_q == S_IDLE) & div_startE) | (state_q == S_BUSY));
  assign result_valid = ~flush & (state_q == S_DONE);
  assign hi_out       = hi_q;
  assign lo_out       = lo_q;

endmodule

// File: tb/tb_div_unit.sv
// Testbench for div_unit: directed cases plus randomized divides against a
// plain-arithmetic reference model.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        div_startE;
  logic        signed_divE;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        cache_stall;
  logic        div_stall;
  logic        result_valid;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  int vecs = 0;
  int errs = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .div_startE   (div_startE),
    .signed_divE  (signed_divE),
    .a            (a),
    .b            (b),
    .flush        (flush),
    .cache_stall  (cache_stall),
    .div_stall    (div_stall),
    .result_valid (result_valid),
    .hi_out       (hi_out),
    .lo_out       (lo_out)
  );

  always #5 clk = ~clk;

  // Reference: MIPS-style div/divu with deterministic divide-by-zero.
  function automatic void ref_div(input logic [31:0] av, input logic [31:0] bv,
                                  input logic sgn,
                                  output logic [31:0] q, output logic [31:0] r);
    longint sa;
    longint sb;
    if (bv == 32'd0) begin
      r = av;
      q = (sgn && $signed(av) < 0) ? 32'd1 : 32'hFFFF_FFFF;
    end else if (!sgn) begin
      q = av / bv;
      r = av % bv;
    end else begin
      sa = longint'($signed(av));
      sb = longint'($signed(bv));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end
  endfunction

  // Issues one divide starting at the next negedge; returns sampled in the
  // first result_valid cycle with div_startE still high.
  task automatic do_div(input logic [31:0] av, input logic [31:0] bv,
                        input logic sgn, input string name);
    logic [31:0] eq;
    logic [31:0] er;
    int cyc;
    int stalls;
    bit got;
    ref_div(av, bv, sgn, eq, er);
    @(negedge clk);
    div_startE  = 1'b1;
    signed_divE = sgn;
    a           = av;
    b           = bv;
    cyc = 0; stalls = 0; got = 0;
    while (!got && cyc < 60) begin
      #1;
      if (result_valid) got = 1;
      else begin
        if (div_stall) stalls++;
        cyc++;
        @(negedge clk);
      end
    end
    vecs++;
    if (!got) begin
      errs++;
      $display("FAIL %s timeout: no result_valid after %0d cycles", name, cyc);
    end
    vecs++;
    if (cyc !== 33 || stalls !== 33) begin
      errs++;
      $display("FAIL %s latency: valid at cycle %0d stall cycles %0d, want 33/33", name, cyc, stalls);
    end
    vecs++;
    if (lo_out !== eq) begin
      errs++;
      $display("FAIL %s lo: got %h want %h", name, lo_out, eq);
    end
    vecs++;
    if (hi_out !== er) begin
      errs++;
      $display("FAIL %s hi: got %h want %h", name, hi_out, er);
    end
    vecs++;
    if (div_stall !== 1'b0) begin
      errs++;
      $display("FAIL %s stall_in_done: got %b want 0", name, div_stall);
    end
  endtask

  task automatic go_idle();
    @(negedge clk);
    div_startE  = 1'b0;
    cache_stall = 1'b0;
    flush       = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; div_startE = 1'b0; signed_divE = 1'b0; a = '0; b = '0;
    flush = 1'b0; cache_stall = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    vecs++;
    if (hi_out !== 32'd0 || lo_out !== 32'd0 || result_valid !== 1'b0 || div_stall !== 1'b0) begin
      errs++;
      $display("FAIL reset: hi %h lo %h valid %b stall %b, want all 0", hi_out, lo_out, result_valid, div_stall);
    end
  endtask

  task automatic test_directed();
    do_div(32'd100, 32'd7, 1'b0, "u100_7");           go_idle();
    do_div(32'hFFFF_FFF9, 32'd2, 1'b1, "s-7_2");       go_idle();
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "ovf"); go_idle();
    do_div(32'd5, 32'd0, 1'b0, "u5_0");                go_idle();
    do_div(32'hFFFF_FFFB, 32'd0, 1'b1, "s-5_0");       go_idle();
    do_div(32'd7, 32'hFFFF_FFFE, 1'b1, "s7_-2");       go_idle();
  endtask

  task automatic test_hold();
    logic [31:0] hl;
    logic [31:0] ll;
    do_div(32'd1000, 32'd33, 1'b0, "hold_div");
    hl = hi_out; ll = lo_out;
    cache_stall = 1'b1;   // mid DONE cycle, before the next edge
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      vecs++;
      if (result_valid !== 1'b1 || div_stall !== 1'b0 || hi_out !== hl || lo_out !== ll) begin
        errs++;
        $display("FAIL hold cycle %0d: valid %b stall %b hi %h lo %h, want 1 0 %h %h",
                 i, result_valid, div_stall, hi_out, lo_out, hl, ll);
      end
    end
    // Still holding DONE from the last held cycle; release now.
    cache_stall = 1'b0;
    // Next div enters E the cycle after DONE exits.
    do_div(32'd20, 32'd3, 1'b0, "after_hold");
    // Back-to-back: third div enters immediately after the second.
    do_div(32'hFFFF_FF00, 32'd10, 1'b1, "b2b");
    go_idle();
    #1;
    vecs++;
    if (result_valid !== 1'b0 || div_stall !== 1'b0) begin
      errs++;
      $display("FAIL idle_after_b2b: valid %b stall %b, want 0 0", result_valid, div_stall);
    end
  endtask

  task automatic test_flush();
    logic [31:0] hl;
    logic [31:0] ll;
    hl = hi_out; ll = lo_out;
    // Flush together with start: no accept.
    @(negedge clk);
    div_startE = 1'b1; signed_divE = 1'b0; a = 32'd77; b = 32'd5; flush = 1'b1;
    #1;
    vecs++;
    if (div_stall !== 1'b0) begin
      errs++;
      $display("FAIL flush_at_start stall: got %b want 0", div_stall);
    end
    @(negedge clk);
    div_startE = 1'b0; flush = 1'b0;
    #1;
    vecs++;
    if (div_stall !== 1'b0) begin
      errs++;
      $display("FAIL flush_at_start state: stall %b want 0 (still idle)", div_stall);
    end
    // Flush at BUSY cycle 10.
    @(negedge clk);
    div_startE = 1'b1;
    for (int i = 0; i < 10; i++) @(negedge clk);
    flush = 1'b1;
    #1;
    vecs++;
    if (div_stall !== 1'b0 || result_valid !== 1'b0) begin
      errs++;
      $display("FAIL flush_busy: stall %b valid %b, want 0 0", div_stall, result_valid);
    end
    @(negedge clk);
    flush = 1'b0; div_startE = 1'b0;
    #1;
    vecs++;
    if (div_stall !== 1'b0 || result_valid !== 1'b0 || hi_out !== hl || lo_out !== ll) begin
      errs++;
      $display("FAIL flush_after: stall %b valid %b hi %h lo %h, want 0 0 %h %h",
               div_stall, result_valid, hi_out, lo_out, hl, ll);
    end
  endtask

  task automatic test_rst_busy();
    @(negedge clk);
    div_startE = 1'b1; signed_divE = 1'b1; a = 32'd12345; b = 32'd17;
    for (int i = 0; i < 5; i++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; div_startE = 1'b0;
    #1;
    vecs++;
    if (hi_out !== 32'd0 || lo_out !== 32'd0 || result_valid !== 1'b0 || div_stall !== 1'b0) begin
      errs++;
      $display("FAIL rst_busy: hi %h lo %h valid %b stall %b, want all 0",
               hi_out, lo_out, result_valid, div_stall);
    end
    do_div(32'd9, 32'd3, 1'b0, "after_rst");
    go_idle();
  endtask

  task automatic test_random();
    logic [31:0] av;
    logic [31:0] bv;
    logic sgn;
    for (int i = 0; i < 24; i++) begin
      av  = $urandom;
      bv  = $urandom;
      sgn = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: bv = 32'($urandom_range(0, 15));
        1: bv = 32'(-int'($urandom_range(1, 9)));
        2: av = 32'($urandom_range(0, 100));
        default: ;
      endcase
      do_div(av, bv, sgn, "random");
      go_idle();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_flush();
    test_rst_busy();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
